// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR tap engine around an external fixed-point multiplier
// Circular delay line, one tap per cycle, N-bit saturating accumulation.
module fir_mac_sequencer #(
   parameter int N    = 16,
   parameter int TAPS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N-1:0]            in_data,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [N-1:0]            coef_data,
   output logic [N-1:0]            mul_a,
   output logic [N-1:0]            mul_b,
   input  logic [N-1:0]            mul_result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N-1:0]            out_data
);

   localparam int PW = $clog2(TAPS);
   localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t        r_state;
   logic [PW-1:0] r_p;
   logic [PW-1:0] r_k;
   logic [N-1:0]  r_acc;
   logic [N-1:0]  r_buf  [TAPS];
   logic [N-1:0]  r_coef [TAPS];
   logic          r_out_valid;
   logic [N-1:0]  r_out_data;

   logic [PW-1:0] w_rd_idx;
   logic [PW-1:0] w_p_next;
   logic [N-1:0]  w_sum;

   function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] s;
      s = a + b;
      if ((a[N-1] == b[N-1]) && (s[N-1] != a[N-1]))
         s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      return s;
   endfunction

   // (p - k) mod TAPS; for power-of-two TAPS the natural wrap already gives it
   always_comb begin
      w_rd_idx = r_p - r_k;
      if (r_p < r_k)
         w_rd_idx = r_p + PW'(TAPS) - r_k;
   end

   assign w_p_next = (r_p == LAST) ? '0 : r_p + PW'(1);
   assign w_sum    = sat_add(r_acc, mul_result);

   assign in_ready  = (r_state == S_IDLE);
   assign mul_a     = (r_state == S_MAC) ? r_buf[w_rd_idx] : '0;
   assign mul_b     = (r_state == S_MAC) ? r_coef[r_k] : '0;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_p         <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int i = 0; i < TAPS; i++) begin
            r_buf[i]  <= '0;
            r_coef[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (coef_we && (int'(coef_addr) < TAPS))
                  r_coef[coef_addr] <= coef_data;
               if (in_valid) begin
                  r_p            <= w_p_next;
                  r_buf[w_p_next] <= in_data;
                  r_acc          <= '0;
                  r_k            <= '0;
                  r_state        <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_sum;
               r_k   <= r_k + PW'(1);
               if (r_k == LAST) begin
                  r_out_data  <= w_sum;
                  r_out_valid <= 1'b1;
                  r_k         <= '0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer with a Q8.8 multiplier model
module tb_fir_mac_sequencer;

   localparam int N    = 16;
   localparam int TAPS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_data = '0;
   logic          coef_we = 1'b0;
   logic [1:0]    coef_addr = '0;
   logic [N-1:0]  coef_data = '0;
   logic [N-1:0]  mul_a;
   logic [N-1:0]  mul_b;
   logic [N-1:0]  mul_result;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  out_data;

   int            n_vec = 0;
   int            n_err = 0;
   logic [15:0]   exp_q [$];
   logic [15:0]   m_coef [TAPS];
   logic [15:0]   m_hist [TAPS];

   always #5 clk = ~clk;

   fir_mac_sequencer #(.N(N), .TAPS(TAPS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   function automatic logic [15:0] mulq(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      p = $signed(a) * $signed(b);
      p = p >>> 8;
      if (p > 32767) return 16'h7FFF;
      if (p < -32768) return 16'h8000;
      return p[15:0];
   endfunction

   function automatic logic [15:0] sadd(input logic [15:0] a, input logic [15:0] b);
      logic signed [16:0] s;
      s = $signed({a[15], a}) + $signed({b[15], b});
      if (s > 17'sd32767) return 16'h7FFF;
      if (s < -17'sd32768) return 16'h8000;
      return s[15:0];
   endfunction

   assign mul_result = mulq(mul_a, mul_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_y();
      logic [15:0] acc;
      acc = 16'h0000;
      for (int k = 0; k < TAPS; k++)
         acc = sadd(acc, mulq(m_hist[k], m_coef[k]));
      return acc;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         m_coef[i] = '0;
         m_hist[i] = '0;
      end
      exp_q.delete();
   endtask

   // all tasks start and end just after a falling edge
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wr_coef(input int addr, input logic [15:0] data);
      coef_we = 1'b1; coef_addr = 2'(addr); coef_data = data;
      m_coef[addr] = data;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic do_sample(input logic [15:0] x, input bit we, input int addr,
                            input logic [15:0] data, input int hold);
      int          lat;
      logic [15:0] e;
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; in_data = x;
      if (we) begin
         coef_we = 1'b1; coef_addr = 2'(addr); coef_data = data;
         m_coef[addr] = data;
      end
      for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = x;
      exp_q.push_back(model_y());
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b0; in_data = 16'($urandom);
      chk("in_ready_mac", in_ready, 0);
      chk("mul_a_k0", mul_a, x);
      chk("mul_b_k0", mul_b, m_coef[0]);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, TAPS);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("out_data", out_data, e);
      for (int h = 0; h < hold; h++) begin
         coef_we = 1'b1; coef_addr = 2'(h); coef_data = 16'h7FFF;
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, e);
         chk("bp_in_ready", in_ready, 0);
      end
      coef_we = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_clr", out_valid, 0);
      chk("mul_a_idle", mul_a, 0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);

      wr_coef(0, 16'h0100); wr_coef(1, 16'h0080);
      do_sample(16'h0200, 0, 0, 0, 0);
      do_sample(16'h0400, 0, 0, 0, 0);

      do_reset();
      wr_coef(0, 16'h0100); wr_coef(1, 16'h0200); wr_coef(2, 16'h0300); wr_coef(3, 16'h0400);
      do_sample(16'h0100, 0, 0, 0, 0);
      repeat (4) do_sample(16'h0000, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < TAPS; i++) wr_coef(i, 16'h7F00);
      do_sample(16'h0200, 0, 0, 0, 0);
      do_sample(16'hFE00, 0, 0, 0, 0);

      do_reset();
      wr_coef(0, 16'h0100); wr_coef(1, 16'h0080);
      do_sample(16'h0300, 0, 0, 0, 5);
      do_sample(16'h0100, 0, 0, 0, 0);
      do_sample(16'h0200, 1, 1, 16'h0100, 0);

      chk("in_ready_mid", in_ready, 1);
      in_valid = 1'b1; in_data = 16'h0300;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_mul_b", mul_b, 0);
      do_sample(16'h0100, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < TAPS; i++) wr_coef(i, 16'($urandom));
      for (int j = 0; j < 10; j++)
         do_sample(16'($urandom), ($urandom_range(0, 1) == 1), int'($urandom_range(0, TAPS - 1)),
                   16'($urandom), int'($urandom_range(0, 2)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
